// File: rtl/pc_sequencer.sv
// Multi-cycle instruction sequencer: fetch handshake, 3-bit opcode decode, PC next-address
// generation and a small return-address stack for CALL/RET.
module pc_sequencer #(
  parameter int AW          = 13,
  parameter int STACK_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] pc_cur,
  input  logic [15:0]   instr,
  input  logic          mem_ack,
  input  logic          zero,
  output logic          mem_rd,
  output logic          ir_ld,
  output logic          exec_en,
  output logic          pc_ld,
  output logic [AW-1:0] pc_next,
  output logic          busy,
  output logic          halted,
  output logic          stack_err
);

  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

  localparam logic [2:0] OP_ALU  = 3'b000;
  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_JZ   = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_UPDATE, S_HALT
  } state_t;

  state_t         r_state;
  logic [2:0]     r_opcode;
  logic [AW-1:0]  r_target;
  logic [SPW-1:0] r_sp;
  // Sized to the full pointer range so any pointer value indexes a real entry.
  logic [AW-1:0]  r_stack [0:(1<<SPW)-1];

  logic [AW-1:0]  w_inc;
  logic [AW-1:0]  w_top;
  logic [AW-1:0]  w_next;
  logic [SPW-1:0] w_sp_m1;
  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_to_halt;
  logic           w_err;

  assign w_inc   = pc_cur + AW'(1);
  assign w_full  = (r_sp == SP_FULL);
  assign w_empty = (r_sp == '0);
  assign w_sp_m1 = r_sp - SPW'(1);
  assign w_top   = r_stack[w_sp_m1];
  assign w_push  = (r_state == S_DECODE) && (r_opcode == OP_CALL) && !w_full;
  assign ir_ld   = (r_state == S_FETCH) && mem_ack;

  always_comb begin
    w_next    = w_inc;
    w_to_halt = 1'b0;
    w_err     = 1'b0;
    case (r_opcode)
      OP_JMP:  w_next = r_target;
      OP_JZ:   if (zero) w_next = r_target;
      OP_CALL: begin
        w_next = r_target;
        if (w_full) begin
          w_to_halt = 1'b1;
          w_err     = 1'b1;
        end
      end
      OP_RET: begin
        w_next = w_top;
        if (w_empty) begin
          w_to_halt = 1'b1;
          w_err     = 1'b1;
        end
      end
      OP_HALT: w_to_halt = 1'b1;
      default: ;
    endcase
  end

  // Stack contents need no reset: a cleared pointer makes them unreachable.
  always_ff @(posedge clk) begin
    if (w_push) r_stack[r_sp] <= w_inc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_opcode  <= '0;
      r_target  <= '0;
      r_sp      <= '0;
      mem_rd    <= 1'b0;
      exec_en   <= 1'b0;
      pc_ld     <= 1'b0;
      pc_next   <= '0;
      busy      <= 1'b0;
      halted    <= 1'b0;
      stack_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_FETCH;
            mem_rd  <= 1'b1;
            busy    <= 1'b1;
          end
        end
        S_FETCH: begin
          if (mem_ack) begin
            r_opcode <= instr[15:13];
            r_target <= instr[AW-1:0];
            mem_rd   <= 1'b0;
            r_state  <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (w_to_halt) begin
            r_state <= S_HALT;
            halted  <= 1'b1;
            busy    <= 1'b0;
            if (w_err) stack_err <= 1'b1;
          end else begin
            r_state <= S_EXEC;
            pc_next <= w_next;
            exec_en <= (r_opcode == OP_ALU);
            if (r_opcode == OP_CALL)     r_sp <= r_sp + SPW'(1);
            else if (r_opcode == OP_RET) r_sp <= w_sp_m1;
          end
        end
        S_EXEC: begin
          exec_en <= 1'b0;
          pc_ld   <= 1'b1;
          r_state <= S_UPDATE;
        end
        S_UPDATE: begin
          pc_ld   <= 1'b0;
          mem_rd  <= 1'b1;
          r_state <= S_FETCH;
        end
        S_HALT: ;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle instruction sequencer that owns the 13-bit program counter register. It drives the PC's load strobe and next-address value, fetches from instruction memory over a request/acknowledge handshake, and decodes a 3-bit opcode. It resolves jumps, conditional branches and call/return through a small internal return-address stack, and pulses the datapath execute enable for ALU instructions.

## Interface
- AW, 13, address width; must equal the PC register width
- STACK_DEPTH, 4, return-stack entries; 1..16
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin execution; sampled only in IDLE
- pc_cur  in  AW  current PC register output; also used as the fetch address by memory
- instr  in  16  memory read data; opcode = instr[15:13], target = instr[AW-1:0]
- mem_ack  in  1  memory data valid; sampled only in FETCH
- zero  in  1  datapath zero flag; sampled in DECODE
- mem_rd  out  1  fetch request
- ir_ld  out  1  instruction-register load strobe
- exec_en  out  1  datapath execute strobe
- pc_ld  out  1  PC load strobe
- pc_next  out  AW  PC load value; registered
- busy  out  1  high in every state except IDLE and HALT
- halted  out  1  high in HALT
- stack_err  out  1  sticky return-stack over/underflow flag

## Operation
- States: IDLE, FETCH, DECODE, EXEC, UPDATE, HALT.
- IDLE: all strobes low. start=1 moves to FETCH.
- FETCH:
  - mem_rd=1 and held until mem_ack=1.
  - In the ack cycle, ir_ld=1 combinationally, instr is captured into an internal opcode/target register, and the state moves to DECODE.
  - No timeout.
- DECODE:
  - Computes the next PC into pc_next; the register updates on the exit edge.
  - inc = pc_cur + 1, truncated to AW bits, so 8191 wraps to 0.
  - Opcode actions:
    - 000 ALU: next = inc.
    - 001 JMP: next = target.
    - 010 JZ: next = target if zero=1, else inc.
    - 011 CALL: push inc; next = target.
    - 100 RET: pop; next = popped value.
    - 101 HALT: go to HALT directly; no PC load.
    - 110, 111 NOP: next = inc.
  - CALL with a full stack or RET with an empty stack sets stack_err=1, leaves the stack pointer and stack unchanged, and goes to HALT; no PC load.
  - Every other opcode moves to EXEC.
- EXEC: exec_en=1 for one cycle for opcode 000 only. Always moves to UPDATE.
- UPDATE: pc_ld=1 for one cycle with pc_next stable, then moves to FETCH.
- HALT: halted=1. Exits only by reset; start is ignored.
- Stack:
  - LIFO of STACK_DEPTH entries × AW bits, with pointer sp in 0..STACK_DEPTH.
  - Push writes [sp] then sp+1; pop reads [sp-1] then sp-1.
  - A full stack (sp=STACK_DEPTH) accepts no push.
- start outside IDLE and mem_ack outside FETCH are ignored.

## Timing
- Reset values:
  - State: IDLE.
  - Outputs: mem_rd, ir_ld, exec_en, pc_ld, busy, halted and stack_err all 0; pc_next=0.
  - Internal: sp=0, opcode/target register 0.
- Reset mid-operation abandons the instruction immediately. No pc_ld is issued, and the stack contents are discarded (sp=0).
- Cycle timing, with mem_ack in cycle N:
  - ir_ld at N.
  - DECODE at N+1.
  - EXEC at N+2, with exec_en if ALU.
  - UPDATE at N+3, with pc_ld.
  - FETCH at N+4, with mem_rd and pc_cur already holding the new value.
- Minimum instruction period is 4 cycles (ack in the first FETCH cycle); each cycle of ack delay adds one.
- HALT/error path: DECODE at N+1, halted=1 from N+2.
- busy rises the cycle after start is sampled.
- pc_ld and exec_en never assert in the same cycle. Exactly one pc_ld is issued per non-halting instruction.

## Test plan
- Reset, start, ALU at address 0 with ack delayed 2 cycles: mem_rd high for 3 cycles; exec_en one cycle; pc_ld with pc_next=1; next mem_rd 4 cycles after ack.
- JZ target=0x100: with zero=1, pc_next=0x100; with zero=0 from pc 0x020, pc_next=0x021; no exec_en in either case.
- CALL 0x200 from pc 0x010, then RET: pc_next=0x200, then 0x011; sp returns to 0.
- Five nested CALLs with STACK_DEPTH=4: first four load their targets; the fifth gives stack_err=1, halted=1, no pc_ld. RET on an empty stack after reset gives the same result.
- ALU at pc 0x1FFF: pc_next=0x0000 (wrap). HALT opcode: halted=1, start ignored for 10 cycles, no mem_rd.
- rst asserted during EXEC of a CALL: all outputs 0 asynchronously; after release, state IDLE, sp=0, no pc_ld observed.
